mem_axi_arbiter: RTL and testbench

- Shares the single AXI master translation path between the instruction-fetch port (read-only, I side) and the data port (read/write, D side).
- Sits between the core's memory stage and the AXI translator.
- Grants one requester at a time, forwards one word transaction downstream, and returns the response to the owner.
- Default policy is fixed D-over-I priority with a starvation guard for I.

---
 rtl/mem_axi_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_axi_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_arbiter.sv
// mem_axi_arbiter: shares one downstream word-transaction path between the I-fetch and D ports.
// Build option ARB_ROUND_ROBIN_EN: alternate owners on contention instead of D priority + MAX_WAIT guard.
module mem_axi_arbiter #(
    parameter  int unsigned MAX_WAIT = 4,
    localparam int unsigned AW       = 32,
    localparam int unsigned DW       = 32,
    localparam int unsigned SW       = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_ACK,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    input  logic [SW-1:0] D_STRB,
    output logic          D_ACK,
    output logic [DW-1:0] D_RDATA,
    output logic          M_REQ,
    output logic          M_WE,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    output logic [SW-1:0] M_STRB,
    input  logic          M_ACK,
    input  logic [DW-1:0] M_RDATA,
    output logic          BUSY,
    output logic          OWNER_D
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state, state_n;
    logic          m_req_n, m_we_n, owner_d_n, busy_n;
    logic [AW-1:0] m_addr_n;
    logic [DW-1:0] m_wdata_n;
    logic [SW-1:0] m_strb_n;
    logic          i_ack_n, d_ack_n;
    logic [DW-1:0] i_rdata_n, d_rdata_n;
    logic          any_req_c, grant_d_c;

    assign any_req_c = I_REQ | D_REQ;

`ifdef ARB_ROUND_ROBIN_EN
    // Last owner resets to I so D wins the first contention.
    logic last_d, last_d_n;
    assign grant_d_c = D_REQ & (~I_REQ | ~last_d);
`else
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    assign grant_d_c = D_REQ & (~I_REQ | (wait_cnt != CW'(MAX_WAIT)));
`endif

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            M_STRB  <= '0;
            I_ACK   <= 1'b0;
            I_RDATA <= '0;
            D_ACK   <= 1'b0;
            D_RDATA <= '0;
            BUSY    <= 1'b0;
            OWNER_D <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= 1'b0;
`else
            wait_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            M_REQ   <= m_req_n;
            M_WE    <= m_we_n;
            M_ADDR  <= m_addr_n;
            M_WDATA <= m_wdata_n;
            M_STRB  <= m_strb_n;
            I_ACK   <= i_ack_n;
            I_RDATA <= i_rdata_n;
            D_ACK   <= d_ack_n;
            D_RDATA <= d_rdata_n;
            BUSY    <= busy_n;
            OWNER_D <= owner_d_n;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= last_d_n;
`else
            wait_cnt <= wait_cnt_n;
`endif
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (any_req_c) state_n = S_BUSY;
            S_BUSY:  if (M_ACK) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        m_req_n   = M_REQ;
        m_we_n    = M_WE;
        m_addr_n  = M_ADDR;
        m_wdata_n = M_WDATA;
        m_strb_n  = M_STRB;
        owner_d_n = OWNER_D;
        i_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        i_rdata_n = '0;
        d_rdata_n = '0;
        busy_n    = (state_n != S_IDLE);
`ifdef ARB_ROUND_ROBIN_EN
        last_d_n  = last_d;
`else
        wait_cnt_n = wait_cnt;
`endif
        case (state)
            S_IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
                if (!I_REQ) wait_cnt_n = '0;
`endif
                if (any_req_c) begin
                    m_req_n   = 1'b1;
                    owner_d_n = grant_d_c;
                    if (grant_d_c) begin
                        m_we_n    = D_WE;
                        m_addr_n  = D_ADDR;
                        m_wdata_n = D_WDATA;
                        m_strb_n  = D_STRB;
                    end else begin
                        m_we_n    = 1'b0;
                        m_addr_n  = I_ADDR;
                        m_wdata_n = '0;
                        m_strb_n  = '1;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_n = grant_d_c;
`else
                    // Count D grants that made a waiting I requester stand aside
                    if (!grant_d_c) begin
                        wait_cnt_n = '0;
                    end else if (I_REQ && (wait_cnt < CW'(MAX_WAIT))) begin
                        wait_cnt_n = wait_cnt + CW'(1);
                    end
`endif
                end
            end
            S_BUSY: begin
                if (M_ACK) begin
                    m_req_n   = 1'b0;
                    m_we_n    = 1'b0;
                    m_addr_n  = '0;
                    m_wdata_n = '0;
                    m_strb_n  = '0;
                    if (OWNER_D) begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = M_WE ? '0 : M_RDATA;
                    end else begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = M_RDATA;
                    end
                end
            end
            S_DONE: begin
                owner_d_n = 1'b0;
            end
            default: begin
                m_req_n   = 1'b0;
                m_we_n    = 1'b0;
                m_addr_n  = '0;
                m_wdata_n = '0;
                m_strb_n  = '0;
                owner_d_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Testbench for mem_axi_arbiter: directed timing checks, then randomized requesters scored against a
// grant/response reference model. Honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_axi_arbiter;

    localparam int unsigned TB_MAX_WAIT = 4;
    localparam int unsigned N_SAT       = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ, I_ACK;
    logic [31:0] I_ADDR, I_RDATA;
    logic        D_REQ, D_WE, D_ACK;
    logic [31:0] D_ADDR, D_WDATA, D_RDATA;
    logic [3:0]  D_STRB;
    logic        M_REQ, M_WE, M_ACK;
    logic [31:0] M_ADDR, M_WDATA, M_RDATA;
    logic [3:0]  M_STRB;
    logic        BUSY, OWNER_D;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } m_txn_t;

    m_txn_t      m_exp_q[$];
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic        grant_log[$];

    bit agents_en = 0, resp_en = 0, mon_en = 0, i_act = 0, d_act = 0;
    int unsigned gap_max = 3;

    always #5 CLK = ~CLK;

    mem_axi_arbiter #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_STRB(M_STRB),
        .M_ACK(M_ACK), .M_RDATA(M_RDATA),
        .BUSY(BUSY), .OWNER_D(OWNER_D)
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Directed D transaction; fields are scrambled after grant to prove they were captured
    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] rdata, input int dly);
        tick();
        D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_STRB = strb;
        tick();
        chk("dir_m_req", 32'(M_REQ), 32'd1);
        chk("dir_m_we", 32'(M_WE), 32'(we));
        chk("dir_m_addr", M_ADDR, addr);
        chk("dir_m_wdata", M_WDATA, wdata);
        chk("dir_m_strb", 32'(M_STRB), 32'(strb));
        chk("dir_owner_d", 32'(OWNER_D), 32'd1);
        D_ADDR = ~addr; D_WDATA = ~wdata; D_WE = ~we;
        for (int i = 0; i < dly; i++) begin
            M_ACK = 1'b0;
            tick();
            chk("dir_m_hold", M_ADDR, addr);
        end
        M_ACK = 1'b1; M_RDATA = rdata;
        tick();
        M_ACK = 1'b0; D_REQ = 1'b0;
        chk("dir_d_ack", 32'(D_ACK), 32'd1);
        chk("dir_d_rdata", D_RDATA, we ? 32'd0 : rdata);
        chk("dir_i_ack_quiet", 32'(I_ACK), 32'd0);
        chk("dir_m_req_clr", 32'(M_REQ), 32'd0);
        tick();
        chk("dir_d_ack_pulse", 32'(D_ACK), 32'd0);
        chk("dir_d_rdata_clr", D_RDATA, 32'd0);
        chk("dir_busy_clr", 32'(BUSY), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        agents_en = 0;
        while ((i_act || d_act || BUSY) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) flag("drain_timeout");
        repeat (6) @(posedge CLK);
        #1;
    endtask

    // I requester agent
    initial begin : i_agent
        int gap, age;
        logic [31:0] a;
        gap = 0; age = 0;
        forever begin
            tick();
            if (i_act) begin
                age++;
                if (I_ACK) begin
                    i_act = 0; I_REQ = 1'b0; gap = int'($urandom_range(0, gap_max));
                end else if (age > 100) begin
                    flag("i_ack_timeout"); i_act = 0; I_REQ = 1'b0;
                end
            end else if (gap > 0) gap--;
            if (!i_act && agents_en && gap == 0) begin
                a = $urandom & 32'hFFFF_FFFC;
                I_ADDR = a; I_REQ = 1'b1; i_act = 1; age = 0;
                i_exp_q.push_back(rdata_of(a));
            end
        end
    end

    // D requester agent
    initial begin : d_agent
        int gap, age;
        logic [31:0] a;
        logic we;
        gap = 0; age = 0;
        forever begin
            tick();
            if (d_act) begin
                age++;
                if (D_ACK) begin
                    d_act = 0; D_REQ = 1'b0; gap = int'($urandom_range(0, gap_max));
                end else if (age > 100) begin
                    flag("d_ack_timeout"); d_act = 0; D_REQ = 1'b0;
                end
            end else if (gap > 0) gap--;
            if (!d_act && agents_en && gap == 0) begin
                a  = $urandom & 32'hFFFF_FFFC;
                we = 1'($urandom_range(0, 1));
                D_ADDR = a; D_WE = we; D_WDATA = $urandom; D_STRB = 4'($urandom_range(1, 15));
                D_REQ = 1'b1; d_act = 1; age = 0;
                d_exp_q.push_back(we ? 32'd0 : rdata_of(a));
            end
        end
    end

    // Downstream responder: random latency, stray M_ACK pulses while idle
    initial begin : responder
        int dly;
        dly = 0;
        forever begin
            tick();
            if (resp_en) begin
                if (M_REQ) begin
                    if (dly == 0) begin
                        M_ACK = 1'b1; M_RDATA = rdata_of(M_ADDR); dly = int'($urandom_range(0, 2));
                    end else begin
                        dly--; M_ACK = 1'b0; M_RDATA = $urandom;
                    end
                end else begin
                    M_ACK = ($urandom_range(0, 3) == 0); M_RDATA = $urandom;
                end
            end
        end
    end

    // Monitor: reference arbitration model plus response scoreboard
    initial begin : monitor
        logic prev_mreq, prev_iack, prev_dack, grant_exp, gd;
        m_txn_t cur, e;
`ifdef ARB_ROUND_ROBIN_EN
        logic last_d;
        last_d = 1'b0;
`else
        int unsigned streak;
        streak = 0;
`endif
        prev_mreq = 0; prev_iack = 0; prev_dack = 0; grant_exp = 0; cur = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                grant_exp = 0;
`ifdef ARB_ROUND_ROBIN_EN
                last_d = 1'b0;
`else
                streak = 0;
`endif
            end else if (mon_en) begin
                if (grant_exp) chk("grant_latency", 32'(M_REQ), 32'd1);
                if (M_REQ && !prev_mreq) begin
                    if (m_exp_q.size() == 0) flag("unexpected_grant");
                    else begin
                        e = m_exp_q.pop_front();
                        cur = e;
                        grant_log.push_back(e.d);
                        chk("owner_d", 32'(OWNER_D), 32'(e.d));
                        chk("m_we", 32'(M_WE), 32'(e.we));
                        chk("m_addr", M_ADDR, e.addr);
                        chk("m_wdata", M_WDATA, e.wdata);
                        chk("m_strb", 32'(M_STRB), 32'(e.strb));
                    end
                end else if (M_REQ) begin
                    chk("m_addr_hold", M_ADDR, cur.addr);
                end
                chk("dual_ack", 32'(I_ACK & D_ACK), 32'd0);
                if (I_ACK) begin
                    chk("i_ack_owner", 32'(cur.d), 32'd0);
                    chk("i_ack_pulse", 32'(prev_iack), 32'd0);
                    if (i_exp_q.size() == 0) flag("i_ack_unexpected");
                    else chk("i_rdata", I_RDATA, i_exp_q.pop_front());
                end else chk("i_rdata_idle", I_RDATA, 32'd0);
                if (D_ACK) begin
                    chk("d_ack_owner", 32'(cur.d), 32'd1);
                    chk("d_ack_pulse", 32'(prev_dack), 32'd0);
                    if (d_exp_q.size() == 0) flag("d_ack_unexpected");
                    else chk("d_rdata", D_RDATA, d_exp_q.pop_front());
                end else chk("d_rdata_idle", D_RDATA, 32'd0);
                grant_exp = 0;
                if (!BUSY) begin
`ifndef ARB_ROUND_ROBIN_EN
                    if (!I_REQ) streak = 0;
`endif
                    if (I_REQ || D_REQ) begin
`ifdef ARB_ROUND_ROBIN_EN
                        gd = D_REQ && !(I_REQ && last_d);
                        last_d = gd;
`else
                        gd = D_REQ && !(I_REQ && streak == TB_MAX_WAIT);
                        if (!gd) streak = 0;
                        else if (I_REQ && streak < TB_MAX_WAIT) streak++;
`endif
                        if (gd) m_exp_q.push_back({1'b1, D_WE, D_ADDR, D_WDATA, D_STRB});
                        else    m_exp_q.push_back({1'b0, 1'b0, I_ADDR, 32'd0, 4'hF});
                        grant_exp = 1;
                    end
                end
            end
            prev_mreq = M_REQ; prev_iack = I_ACK; prev_dack = D_ACK;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        RST = 1'b1; I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0;
        D_WDATA = '0; D_STRB = '0; M_ACK = 1'b0; M_RDATA = '0;
        repeat (3) tick();
        chk("rst_m_req", 32'(M_REQ), 32'd0);
        chk("rst_m_we", 32'(M_WE), 32'd0);
        chk("rst_m_addr", M_ADDR, 32'd0);
        chk("rst_m_wdata", M_WDATA, 32'd0);
        chk("rst_m_strb", 32'(M_STRB), 32'd0);
        chk("rst_acks", 32'({I_ACK, D_ACK}), 32'd0);
        chk("rst_rdata", I_RDATA | D_RDATA, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_owner", 32'(OWNER_D), 32'd0);

        // Minimum turnaround: REQ at cycle 0, M_ACK in cycle 1
        RST = 1'b0; I_REQ = 1'b1; I_ADDR = 32'h40;
        tick();
        chk("b2b_m_req", 32'(M_REQ), 32'd1);
        chk("b2b_m_addr", M_ADDR, 32'h40);
        chk("b2b_m_we", 32'(M_WE), 32'd0);
        chk("b2b_m_strb", 32'(M_STRB), 32'hF);
        chk("b2b_m_wdata", M_WDATA, 32'd0);
        chk("b2b_owner", 32'(OWNER_D), 32'd0);
        chk("b2b_busy", 32'(BUSY), 32'd1);
        M_ACK = 1'b1; M_RDATA = 32'hCAFE_F00D;
        tick();
        chk("b2b_i_ack", 32'(I_ACK), 32'd1);
        chk("b2b_i_rdata", I_RDATA, 32'hCAFE_F00D);
        chk("b2b_d_ack", 32'(D_ACK), 32'd0);
        chk("b2b_m_req_clr", 32'(M_REQ), 32'd0);
        M_ACK = 1'b0; I_ADDR = 32'h44;
        tick();
        chk("b2b_busy_low", 32'(BUSY), 32'd0);
        chk("b2b_i_ack_pulse", 32'(I_ACK), 32'd0);
        tick();
        chk("b2b_regrant", 32'(M_REQ), 32'd1);
        chk("b2b_regrant_addr", M_ADDR, 32'h44);
        M_ACK = 1'b1; M_RDATA = 32'h1;
        tick();
        chk("b2b_i_ack2", 32'(I_ACK), 32'd1);
        M_ACK = 1'b0; I_REQ = 1'b0;
        tick();

        d_txn(1'b0, 32'h1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 2);
        d_txn(1'b1, 32'h2004, 32'h1234_5678, 4'b0011, 32'h5555_AAAA, 0);

        // Reset while the downstream transaction is outstanding
        tick();
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h3000;
        tick();
        chk("rmo_m_req", 32'(M_REQ), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0; D_REQ = 1'b0;
        chk("rmo_m_req_clr", 32'(M_REQ), 32'd0);
        chk("rmo_busy", 32'(BUSY), 32'd0);
        chk("rmo_owner", 32'(OWNER_D), 32'd0);
        chk("rmo_no_ack", 32'({I_ACK, D_ACK}), 32'd0);
        tick();
        chk("rmo_no_ack2", 32'({I_ACK, D_ACK}), 32'd0);
        chk("rmo_idle", 32'(M_REQ), 32'd0);

        // Randomized traffic
        mon_en = 1; resp_en = 1; gap_max = 3;
        @(negedge CLK);
        agents_en = 1;
        repeat (1500) @(posedge CLK);
        #1;
        drain();

        // Saturated contention: both sides re-request immediately
        grant_log.delete();
        gap_max = 0;
        @(negedge CLK);
        agents_en = 1;
        n = 0;
        while (grant_log.size() < N_SAT && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) flag("sat_timeout");
        drain();
        if (grant_log.size() >= N_SAT) begin
            for (int k = 0; k < int'(N_SAT); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (k > 0) chk("rr_alternate", 32'(grant_log[k]), 32'(!grant_log[k-1]));
`else
                chk("sat_order", 32'(grant_log[k]),
                    (k % int'(TB_MAX_WAIT + 1) == int'(TB_MAX_WAIT)) ? 32'd0 : 32'd1);
`endif
            end
        end

        chk("m_exp_q_empty", 32'(m_exp_q.size()), 32'd0);
        chk("i_exp_q_empty", 32'(i_exp_q.size()), 32'd0);
        chk("d_exp_q_empty", 32'(d_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
